// File: rtl/pulse_monitor.sv
// pulse_monitor: receive-side checker for periodic single-cycle strobes.
// Detects rising edges on pulse_in, measures the interval between consecutive
// edges, locks after LOCK_CNT consecutive intervals equal to EXPECT, and flags
// an error when a locked stream arrives early or misses a pulse.
//
// Ports:
//   clk          - clock, all logic on posedge
//   rst          - synchronous active-high reset
//   en           - monitor enable; 0 holds all state
//   pulse_in     - strobe under test
//   locked       - registered; 1 while in LOCKED
//   err          - registered; one-cycle error strobe
//   period_valid - registered; one-cycle strobe when period is updated
//   period       - registered; last measured interval in clk cycles
module pulse_monitor #(
   parameter int unsigned EXPECT   = 4,
   parameter int unsigned LOCK_CNT = 3,
   parameter int unsigned TIMEOUT  = 16
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       pulse_in,
   output logic       locked,
   output logic       err,
   output logic       period_valid,
   output logic [7:0] period
);

   localparam int unsigned CW = 8;
   localparam int unsigned MW = 4;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      MEASURE = 2'd1,
      LOCKED  = 2'd2
   } state_t;

   state_t          state, state_nxt;
   logic [CW-1:0]   cnt, cnt_nxt;
   logic [MW-1:0]   match, match_nxt, match_inc;
   logic            pulse_q;
   logic            locked_nxt, err_nxt, period_valid_nxt;
   logic [CW-1:0]   period_nxt;
   logic            rise;
   logic            at_expect;
   logic            at_timeout;

   // Qualified rising edge; an edge seen while disabled is lost.
   assign rise       = en & pulse_in & ~pulse_q;
   assign at_expect  = (cnt == CW'(EXPECT));
   assign at_timeout = (cnt == CW'(TIMEOUT));
   assign match_inc  = match + MW'(1);

   // State and output registers.
   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= IDLE;
         cnt          <= '0;
         match        <= '0;
         pulse_q      <= 1'b0;
         locked       <= 1'b0;
         err          <= 1'b0;
         period_valid <= 1'b0;
         period       <= '0;
      end else begin
         pulse_q      <= pulse_in;
         state        <= state_nxt;
         cnt          <= cnt_nxt;
         match        <= match_nxt;
         locked       <= locked_nxt;
         err          <= err_nxt;
         period_valid <= period_valid_nxt;
         period       <= period_nxt;
      end
   end

   // Next-state, interval counter and output logic.
   always_comb begin
      state_nxt        = state;
      cnt_nxt          = cnt;
      match_nxt        = match;
      locked_nxt       = locked;
      period_nxt       = period;
      err_nxt          = 1'b0;
      period_valid_nxt = 1'b0;

      if (en) begin
         // Interval counter restarts at 1 on an edge and saturates at all-ones.
         if (rise) begin
            cnt_nxt = CW'(1);
         end else if (cnt != {CW{1'b1}}) begin
            cnt_nxt = cnt + CW'(1);
         end

         unique case (state)
            IDLE: begin
               if (rise) begin
                  match_nxt = '0;
                  state_nxt = MEASURE;
               end
            end

            MEASURE: begin
               if (rise) begin
                  period_nxt       = cnt;
                  period_valid_nxt = 1'b1;
                  if (at_expect) begin
                     match_nxt = match_inc;
                     if (match_inc == MW'(LOCK_CNT)) begin
                        state_nxt  = LOCKED;
                        locked_nxt = 1'b1;
                     end
                  end else begin
                     match_nxt = '0;
                  end
               end else if (at_timeout) begin
                  match_nxt = '0;
                  state_nxt = IDLE;
               end
            end

            LOCKED: begin
               // An edge takes priority, so early and missed errors never coincide.
               if (rise) begin
                  period_nxt       = cnt;
                  period_valid_nxt = 1'b1;
                  if (!at_expect) begin
                     err_nxt    = 1'b1;
                     locked_nxt = 1'b0;
                     match_nxt  = '0;
                     state_nxt  = MEASURE;
                  end
               end else if (at_expect) begin
                  // Missed pulse: cnt keeps running from the last good edge.
                  err_nxt    = 1'b1;
                  locked_nxt = 1'b0;
                  match_nxt  = '0;
                  state_nxt  = MEASURE;
               end
            end

            default: begin
               state_nxt  = IDLE;
               match_nxt  = '0;
               locked_nxt = 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_pulse_monitor.sv
// tb_pulse_monitor: directed bench for pulse_monitor (EXPECT=4, LOCK_CNT=3,
// TIMEOUT=16). Each step drives inputs at the falling edge, pushes the outputs
// expected after the next rising edge onto a scoreboard queue, and pops and
// compares them just after that edge.
module tb_pulse_monitor;

   logic       clk;
   logic       rst;
   logic       en;
   logic       pulse_in;
   logic       locked;
   logic       err;
   logic       period_valid;
   logic [7:0] period;

   typedef struct packed {
      logic       locked;
      logic       err;
      logic       pv;
      logic [7:0] period;
   } exp_t;

   exp_t sb[$];
   int   tests;
   int   fails;
   int   step_no;

   pulse_monitor #(
      .EXPECT   (4),
      .LOCK_CNT (3),
      .TIMEOUT  (16)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .en           (en),
      .pulse_in     (pulse_in),
      .locked       (locked),
      .err          (err),
      .period_valid (period_valid),
      .period       (period)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s step %0d: observed %0d expected %0d", tag, step_no, obs, exp);
      end
   endtask

   // One clock: drive, queue the expectation, then compare after the edge.
   task automatic step(input logic r, input logic e, input logic p,
                       input logic l, input logic er, input logic pv,
                       input logic [7:0] per);
      exp_t x;
      @(negedge clk);
      rst      = r;
      en       = e;
      pulse_in = p;
      sb.push_back({l, er, pv, per});
      @(posedge clk);
      #1;
      step_no++;
      if (sb.size() == 0) begin
         tests++;
         fails++;
         $error("FAIL scoreboard step %0d: observed empty queue expected one entry", step_no);
      end else begin
         x = sb.pop_front();
         chk("locked",       8'(locked),       8'(x.locked));
         chk("err",          8'(err),          8'(x.err));
         chk("period_valid", 8'(period_valid), 8'(x.pv));
         chk("period",       period,           x.period);
      end
   endtask

   // n enabled cycles with the strobe low: no err, no period_valid.
   task automatic quiet(input int n, input logic l, input logic [7:0] per);
      for (int i = 0; i < n; i++) step(1'b0, 1'b1, 1'b0, l, 1'b0, 1'b0, per);
   endtask

   // One enabled cycle with the strobe high.
   task automatic strobe(input logic l, input logic er, input logic pv, input logic [7:0] per);
      step(1'b0, 1'b1, 1'b1, l, er, pv, per);
   endtask

   initial begin
      tests    = 0;
      fails    = 0;
      step_no  = 0;
      rst      = 1'b1;
      en       = 1'b0;
      pulse_in = 1'b0;

      // Reset state.
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

      // 1: steady 4-cycle stream locks on the fourth edge.
      strobe(1'b0, 1'b0, 1'b0, 8'd0);
      quiet(3, 1'b0, 8'd0);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b0, 8'd4);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b0, 8'd4);
      strobe(1'b1, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b1, 8'd4);
      strobe(1'b1, 1'b0, 1'b1, 8'd4);

      // 2: early edge after 3 cycles, then relock after three good intervals.
      quiet(2, 1'b1, 8'd4);
      strobe(1'b0, 1'b1, 1'b1, 8'd3);
      quiet(3, 1'b0, 8'd3);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b0, 8'd4);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b0, 8'd4);
      strobe(1'b1, 1'b0, 1'b1, 8'd4);

      // 3: pulses stop; missed-pulse err 4 cycles after the last edge, then timeout.
      quiet(3, 1'b1, 8'd4);
      step(1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'd4);
      quiet(12, 1'b0, 8'd4);
      strobe(1'b0, 1'b0, 1'b0, 8'd4);
      // Edge at cnt==TIMEOUT is still measured.
      quiet(15, 1'b0, 8'd4);
      strobe(1'b0, 1'b0, 1'b1, 8'd16);

      // 4: unlocked intervals 4,5,4,4,4.
      quiet(3, 1'b0, 8'd16);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(4, 1'b0, 8'd4);
      strobe(1'b0, 1'b0, 1'b1, 8'd5);
      quiet(3, 1'b0, 8'd5);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b0, 8'd4);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);
      quiet(3, 1'b0, 8'd4);
      strobe(1'b1, 1'b0, 1'b1, 8'd4);

      // 5b: en low for 10 cycles mid-lock freezes cnt; no missed-pulse err.
      quiet(1, 1'b1, 8'd4);
      for (int i = 0; i < 10; i++) step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd4);
      quiet(2, 1'b1, 8'd4);
      strobe(1'b1, 1'b0, 1'b1, 8'd4);

      // 6: reset pulse while locked; next edge is treated as the first.
      quiet(1, 1'b1, 8'd4);
      step(1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
      quiet(2, 1'b0, 8'd0);
      strobe(1'b0, 1'b0, 1'b0, 8'd0);
      quiet(3, 1'b0, 8'd0);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);

      // 5a: pulse_in high through reset release and 40 cycles: one event, then IDLE.
      step(1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      for (int i = 0; i < 40; i++) step(1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0);
      quiet(1, 1'b0, 8'd0);
      strobe(1'b0, 1'b0, 1'b0, 8'd0);
      quiet(3, 1'b0, 8'd0);
      strobe(1'b0, 1'b0, 1'b1, 8'd4);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/pulse_monitor.md
Name: pulse_monitor

Overview:
- Receive-side checker for periodic single-cycle strobes from the team's counter-based pulse generators.
- Detects rising edges on pulse_in and measures the cycle interval between consecutive edges.
- Declares lock after LOCK_CNT consecutive intervals equal to EXPECT. Flags an error when a locked stream deviates or drops out.
- Sits at the consuming end of a strobe line: timer ticks, baud/sample strobes, and similar.

Parameters:
EXPECT, 4, expected interval in clk cycles between rising edges (a generator with max=3 gives 4); legal 2..254
LOCK_CNT, 3, consecutive matching intervals required to assert locked; legal 1..15
TIMEOUT, 16, cycles since last edge after which an unlocked monitor returns to IDLE; legal EXPECT+1..255

Ports:
clk  input  1  clock, all logic on posedge
rst  input  1  reset, synchronous, active-high
en  input  1  monitor enable; 0 = hold all state
pulse_in  input  1  strobe under test
locked  output  1  registered; 1 while in LOCKED
err  output  1  registered; one-cycle error strobe
period_valid  output  1  registered; one-cycle strobe, period updated
period  output  8  registered; last measured interval

Behaviour:
- Clocking and reset
  - Reset is synchronous, active-high, on clk. rst dominates every other input.
  - Reset values: state=IDLE, cnt=0, match=0, pulse_q=0, locked=0, err=0, period_valid=0, period=0.
  - rst asserted mid-operation clears everything at the next edge; no err is raised.
- Edge detection
  - pulse_q <= pulse_in on every non-reset edge, regardless of en.
  - event = en & pulse_in & ~pulse_q.
  - Because pulse_q resets to 0, pulse_in high at reset release counts as an event.
  - A rising edge that occurs while en=0 is lost.
  - pulse_in held high produces exactly one event.
- Interval counter cnt (8 bit), updated only when en=1:
  - On an event, cnt <= 1.
  - Otherwise cnt <= cnt+1, saturating at 255.
  - The measured interval is the value of cnt at the event edge. Events on edges k and k+4 give an interval of 4.
- en=0: state, cnt, match, locked and period hold; err=0 and period_valid=0.
- err and period_valid default to 0 every cycle and are set only as listed below. All outputs update on the same edge as the event, so latency is one clock from pulse_in sampled high to the output change.
- IDLE
  - On an event: cnt <= 1, match <= 0, go to MEASURE.
  - No period_valid is produced, since there is no prior edge.
- MEASURE
  - On an event: period <= cnt, period_valid=1.
    - If cnt==EXPECT: match <= match+1. If match+1==LOCK_CNT, go to LOCKED and set locked <= 1.
    - Otherwise: match <= 0, stay in MEASURE, no err.
  - No event and cnt==TIMEOUT: go to IDLE, match <= 0, no err.
- LOCKED
  - Event with cnt==EXPECT: period <= cnt, period_valid=1, stay.
  - Event with cnt!=EXPECT (early): period <= cnt, period_valid=1, err=1, locked <= 0, match <= 0, go to MEASURE.
  - No event and cnt==EXPECT (missed pulse): err=1, locked <= 0, match <= 0, go to MEASURE. cnt keeps counting, so a later edge is measured from the last good edge and TIMEOUT still applies.
- At most one err per edge. The early and missed cases are mutually exclusive because an event takes priority.
- LOCK_CNT=1: the first matching interval locks.

Test Plan:
1. Reset release; en=1; pulse_in high 1 cycle every 4 cycles (edges at cycles 2,6,10,14,18) -> period_valid with period=4 at cycles 6,10,14,18; locked rises at edge 14 and stays; err never asserts.
2. Locked stream, then one edge arrives 3 cycles after the previous -> that edge gives period_valid with period=3, err=1 for one cycle, locked=0. Three further 4-cycle intervals give locked=1 again with no further err.
3. Locked stream, then pulses stop -> err=1 for one cycle exactly 4 cycles after the last edge, locked=0. The state reaches IDLE when cnt==16; a new edge afterwards produces no period_valid.
4. Unlocked intervals 4,5,4,4,4 -> period sequence 4,5,4,4,4; no err; locked asserts only at the edge ending the final interval.
5. pulse_in held high for 40 cycles from reset -> exactly one event, no period_valid, IDLE after 16 cycles. en low for 10 cycles mid-lock with the strobe inactive -> outputs and cnt frozen, locked held, no err.
6. rst pulsed for 1 cycle while LOCKED -> next cycle locked=0, err=0, period=0, period_valid=0. The following edge is treated as the first (IDLE to MEASURE), with no period_valid.
